// File: rtl/myproject_dense_acc.sv
// Dense-layer neuron accumulator: bias-seeded saturating sum of N_IN products,
// round-half-up rescale, optional ReLU, output saturation, valid/ready result.
module myproject_dense_acc #(
  parameter int PROD_WIDTH = 18,
  parameter int BIAS_WIDTH = 12,
  parameter int ACC_WIDTH  = 24,
  parameter int N_IN       = 16,
  parameter int FRAC_SHIFT = 4,
  parameter int OUT_WIDTH  = 16,
  parameter int RELU       = 1
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic signed [PROD_WIDTH-1:0] prod_data,
  input  logic                         prod_valid,
  output logic                         prod_ready,
  input  logic signed [BIAS_WIDTH-1:0] bias,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         acc_ovf
);

  localparam int RW = ACC_WIDTH + 1;
  localparam int CW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_IN - 1);

  logic [CW-1:0]                cnt;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  base;
  logic signed [ACC_WIDTH-1:0]  s;
  logic signed [RW-1:0]         sum;
  logic signed [RW-1:0]         rnd;
  logic signed [RW-1:0]         relu_r;
  logic signed [OUT_WIDTH-1:0]  res;
  logic                         clamp;
  logic                         last_beat;
  logic                         accept;

  assign last_beat  = (cnt == LAST);
  assign prod_ready = !(out_valid && !out_ready && last_beat);
  assign accept     = prod_valid && prod_ready;

  always_comb begin
    base  = (cnt == '0) ? ACC_WIDTH'(bias) : acc;
    sum   = RW'(base) + RW'(prod_data);
    // Overflow iff the two top bits of the one-bit-wider sum disagree.
    clamp = (sum[RW-1] != sum[RW-2]);
    if (clamp)
      s = sum[RW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    else
      s = sum[ACC_WIDTH-1:0];
  end

  generate
    if (FRAC_SHIFT == 0) begin : g_noshift
      assign rnd = RW'(s);
    end else begin : g_shift
      assign rnd = (RW'(s) + RW'(1 << (FRAC_SHIFT - 1))) >>> FRAC_SHIFT;
    end
  endgenerate

  assign relu_r = ((RELU != 0) && rnd[RW-1]) ? '0 : rnd;

  generate
    if (OUT_WIDTH >= RW) begin : g_wide_out
      assign res = OUT_WIDTH'(relu_r);
    end else begin : g_sat_out
      logic [RW-OUT_WIDTH:0] upper;
      assign upper = relu_r[RW-1:OUT_WIDTH-1];
      always_comb begin
        if ((&upper) || !(|upper))
          res = relu_r[OUT_WIDTH-1:0];
        else if (relu_r[RW-1])
          res = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        else
          res = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
    end
  endgenerate

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      cnt       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      acc_ovf   <= 1'b0;
    end else begin
      if (accept) begin
        acc <= s;
        cnt <= last_beat ? '0 : cnt + 1'b1;
        if (clamp)
          acc_ovf <= 1'b1;
      end
      // A new result overrides the consume-clear in the same cycle.
      if (accept && last_beat) begin
        out_data  <= res;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_myproject_dense_acc.sv
// Directed bench for myproject_dense_acc: three instances share stimulus
// (default, RELU=0, and ACC_WIDTH=20/N_IN=16) for the configuration-specific cases.
module tb_myproject_dense_acc;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [17:0] prod_data;
  logic               prod_valid;
  logic signed [11:0] bias;
  logic               out_ready;

  logic               pr0, ov0, ovf0;
  logic signed [15:0] od0;
  logic               pr1, ov1, ovf1;
  logic signed [15:0] od1;
  logic               pr2, ov2, ovf2;
  logic signed [15:0] od2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  myproject_dense_acc #(.N_IN(4)) u0 (
    .ap_clk(clk), .ap_rst(rst), .prod_data(prod_data), .prod_valid(prod_valid),
    .prod_ready(pr0), .bias(bias), .out_data(od0), .out_valid(ov0),
    .out_ready(out_ready), .acc_ovf(ovf0)
  );

  myproject_dense_acc #(.N_IN(4), .RELU(0)) u1 (
    .ap_clk(clk), .ap_rst(rst), .prod_data(prod_data), .prod_valid(prod_valid),
    .prod_ready(pr1), .bias(bias), .out_data(od1), .out_valid(ov1),
    .out_ready(out_ready), .acc_ovf(ovf1)
  );

  myproject_dense_acc #(.ACC_WIDTH(20), .N_IN(16)) u2 (
    .ap_clk(clk), .ap_rst(rst), .prod_data(prod_data), .prod_valid(prod_valid),
    .prod_ready(pr2), .bias(bias), .out_data(od2), .out_valid(ov2),
    .out_ready(out_ready), .acc_ovf(ovf2)
  );

  task automatic do_reset();
    rst = 1'b1;
    prod_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic beat(input logic signed [17:0] d);
    prod_valid = 1'b1;
    prod_data = d;
    @(posedge clk); #1;
    prod_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; prod_valid = 1'b0; out_ready = 1'b1; bias = '0; prod_data = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ov0 !== 1'b0) $display("FAIL reset_valid got %b want 0", ov0); else passed++;
    total++; if (od0 !== 16'sd0) $display("FAIL reset_data got %0d want 0", od0); else passed++;
    total++; if (ovf0 !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf0); else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (pr0 !== 1'b1) $display("FAIL reset_ready got %b want 1", pr0); else passed++;
  endtask

  task automatic test_basic();
    do_reset();
    bias = 12'sd16;
    beat(100); beat(200); beat(-50);
    total++; if (ov0 !== 1'b0) $display("FAIL basic_early_valid got %b want 0", ov0); else passed++;
    beat(30);
    total++; if (ov0 !== 1'b1) $display("FAIL basic_valid got %b want 1", ov0); else passed++;
    total++; if (od0 !== 16'sd19) $display("FAIL basic_data got %0d want 19", od0); else passed++;
    @(posedge clk); #1;
    total++; if (ov0 !== 1'b0) $display("FAIL basic_valid_drop got %b want 0", ov0); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    bias = 12'sd16;
    beat(100); beat(200); beat(-50); beat(30);
    total++; if (od0 !== 16'sd19) $display("FAIL b2b_first got %0d want 19", od0); else passed++;
    bias = 12'sd0;
    beat(10); beat(20); beat(30); beat(40);
    total++; if (ov0 !== 1'b1 || od0 !== 16'sd6)
      $display("FAIL b2b_second got v=%b d=%0d want v=1 d=6", ov0, od0); else passed++;
  endtask

  task automatic test_relu();
    do_reset();
    bias = 12'sd0;
    repeat (4) beat(-100);
    total++; if (od0 !== 16'sd0) $display("FAIL relu_on got %0d want 0", od0); else passed++;
    total++; if (od1 !== -16'sd25) $display("FAIL relu_off got %0d want -25", od1); else passed++;
  endtask

  task automatic test_out_sat();
    do_reset();
    bias = 12'sd0;
    repeat (4) beat(131071);
    total++; if (od0 !== 16'sd32767) $display("FAIL out_sat got %0d want 32767", od0); else passed++;
    total++; if (ovf0 !== 1'b0) $display("FAIL out_sat_ovf got %b want 0", ovf0); else passed++;
  endtask

  task automatic test_acc_sat();
    do_reset();
    bias = 12'sd0;
    repeat (4) beat(131071);
    total++; if (ovf2 !== 1'b0) $display("FAIL acc_ovf_beat4 got %b want 0", ovf2); else passed++;
    beat(131071);
    total++; if (ovf2 !== 1'b1) $display("FAIL acc_ovf_beat5 got %b want 1", ovf2); else passed++;
    repeat (11) beat(131071);
    total++; if (ov2 !== 1'b1 || od2 !== 16'sd32767)
      $display("FAIL acc_sat_data got v=%b d=%0d want v=1 d=32767", ov2, od2); else passed++;
    repeat (16) beat(0);
    total++; if (ovf2 !== 1'b1) $display("FAIL acc_ovf_sticky got %b want 1", ovf2); else passed++;
    total++; if (od2 !== 16'sd0) $display("FAIL acc_sat_next got %0d want 0", od2); else passed++;
    do_reset();
    total++; if (ovf2 !== 1'b0) $display("FAIL acc_ovf_clear got %b want 0", ovf2); else passed++;
  endtask

  task automatic test_backpressure();
    logic signed [17:0] v2 [3];
    v2[0] = 18'sd10; v2[1] = 18'sd20; v2[2] = 18'sd30;
    do_reset();
    bias = 12'sd16;
    beat(100); beat(200); beat(-50); beat(30);
    out_ready = 1'b0;
    total++; if (ov0 !== 1'b1 || od0 !== 16'sd19)
      $display("FAIL bp_first got v=%b d=%0d want v=1 d=19", ov0, od0); else passed++;
    bias = 12'sd0;
    for (int i = 0; i < 3; i++) begin
      prod_valid = 1'b1;
      prod_data = v2[i];
      total++; if (pr0 !== 1'b1) $display("FAIL bp_beat%0d_ready got %b want 1", i, pr0); else passed++;
      @(posedge clk); #1;
    end
    prod_data = 18'sd40;
    total++; if (pr0 !== 1'b0) $display("FAIL bp_stall got %b want 0", pr0); else passed++;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ov0 !== 1'b1 || od0 !== 16'sd19 || pr0 !== 1'b0)
      $display("FAIL bp_hold got v=%b d=%0d r=%b want v=1 d=19 r=0", ov0, od0, pr0); else passed++;
    out_ready = 1'b1;
    #1;
    total++; if (pr0 !== 1'b1) $display("FAIL bp_release_ready got %b want 1", pr0); else passed++;
    @(posedge clk); #1;
    prod_valid = 1'b0;
    total++; if (ov0 !== 1'b1 || od0 !== 16'sd6)
      $display("FAIL bp_second got v=%b d=%0d want v=1 d=6", ov0, od0); else passed++;
    @(posedge clk); #1;
    total++; if (ov0 !== 1'b0) $display("FAIL bp_drain got %b want 0", ov0); else passed++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    bias = 12'sd16;
    beat(100); beat(200); beat(-50); beat(30);
    out_ready = 1'b0;
    beat(100); beat(200);
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (ov0 !== 1'b0 || od0 !== 16'sd0 || ovf0 !== 1'b0)
      $display("FAIL midrst_outputs got v=%b d=%0d o=%b want 0 0 0", ov0, od0, ovf0); else passed++;
    rst = 1'b0;
    out_ready = 1'b1;
    bias = 12'sd16;
    beat(100); beat(200); beat(-50); beat(30);
    total++; if (ov0 !== 1'b1 || od0 !== 16'sd19)
      $display("FAIL midrst_result got v=%b d=%0d want v=1 d=19", ov0, od0); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_relu();
    test_out_sat();
    test_acc_sat();
    test_backpressure();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
